// File: rtl/fp_division_seq_if.sv
// Handshake and data bundle for the sequential single-precision divider.
// Master drives start/operands; slave returns status, quotient and flags.
interface fp_division_seq_if;
  logic        start;
  logic [31:0] a_operand;
  logic [31:0] b_operand;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        Exception;
  logic        Overflow;
  logic        Underflow;

  modport master (
    output start, a_operand, b_operand,
    input  busy, done, result,
    input  Exception, Overflow, Underflow
  );

  modport slave (
    input  start, a_operand, b_operand,
    output busy, done, result,
    output Exception, Overflow, Underflow
  );
endinterface

// File: rtl/fp_division_seq.sv
// Sequential IEEE-754 single divider: restoring mantissa divide,
// one quotient bit per clock, truncated result, denormals flushed.
module fp_division_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int BIAS  = 127
) (
  input  logic               clk,
  input  logic               reset,
  fp_division_seq_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_NORM
  } state_t;

  localparam int MW = MAN_W + 1;
  localparam int SB = EXP_W + MAN_W;
  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  state_t          r_state;
  logic            r_sign;
  logic [9:0]      r_exp;
  logic [MW-1:0]   r_mb;
  logic [MW:0]     r_rem;
  logic [MW:0]     r_q;
  logic [4:0]      r_cnt;
  logic            r_spec;
  logic [31:0]     r_spec_res;
  logic [2:0]      r_spec_flg;
  logic            r_busy;
  logic            r_done;
  logic [31:0]     r_result;
  logic            r_exc;
  logic            r_ovf;
  logic            r_unf;

  logic [EXP_W-1:0] w_ea;
  logic [EXP_W-1:0] w_eb;
  logic [MW-1:0]    w_ma;
  logic [MW-1:0]    w_mb;
  logic             w_sign;
  logic             w_a_max;
  logic             w_b_max;
  logic             w_a_zero;
  logic             w_b_zero;
  logic             w_nan;
  logic             w_dz;
  logic             w_az;
  logic             w_spec;
  logic [31:0]      w_spec_res;
  logic [2:0]       w_spec_flg;
  logic [9:0]       w_exp;
  logic             w_ge;
  logic [MW-1:0]    w_sub;
  logic [MW:0]      w_next_rem;
  logic signed [9:0] w_e_n;
  logic [MAN_W-1:0] w_mant;

  assign w_ea     = bus.a_operand[MAN_W +: EXP_W];
  assign w_eb     = bus.b_operand[MAN_W +: EXP_W];
  assign w_ma     = {1'b1, bus.a_operand[MAN_W-1:0]};
  assign w_mb     = {1'b1, bus.b_operand[MAN_W-1:0]};
  assign w_sign   = bus.a_operand[SB] ^ bus.b_operand[SB];
  assign w_a_max  = (w_ea == EMAX);
  assign w_b_max  = (w_eb == EMAX);
  assign w_a_zero = (w_ea == '0);
  assign w_b_zero = (w_eb == '0);

  // Mutually exclusive special-case classes
  assign w_nan  = w_a_max | w_b_max | (w_a_zero & w_b_zero);
  assign w_dz   = w_b_zero & ~w_a_zero & ~w_a_max;
  assign w_az   = w_a_zero & ~w_b_zero & ~w_b_max;
  assign w_spec = w_nan | w_dz | w_az;

  always_comb begin
    w_spec_res = '0;
    w_spec_flg = '0;
    unique case (1'b1)
      w_nan: begin
        w_spec_res = QNAN;
        w_spec_flg = 3'b100;
      end
      w_dz: begin
        w_spec_res = {w_sign, EMAX, MAN_W'(0)};
        w_spec_flg = 3'b110;
      end
      w_az: begin
        w_spec_res = {w_sign, 31'(0)};
        w_spec_flg = 3'b000;
      end
      default: begin
        w_spec_res = '0;
        w_spec_flg = '0;
      end
    endcase
  end

  assign w_exp = 10'(w_ea) - 10'(w_eb) + 10'(BIAS);

  // Remainder stays below 2*mb, so the low MW bits hold the exact difference
  assign w_ge       = r_rem >= {1'b0, r_mb};
  assign w_sub      = r_rem[MW-1:0] - r_mb;
  assign w_next_rem = w_ge ? {w_sub, 1'b0}
                           : {r_rem[MW-1:0], 1'b0};

  assign w_e_n  = r_q[MW] ? $signed(r_exp)
                          : $signed(r_exp - 10'd1);
  assign w_mant = r_q[MW] ? r_q[MW-1:1] : r_q[MW-2:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_sign     <= 1'b0;
      r_exp      <= '0;
      r_mb       <= '0;
      r_rem      <= '0;
      r_q        <= '0;
      r_cnt      <= '0;
      r_spec     <= 1'b0;
      r_spec_res <= '0;
      r_spec_flg <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_result   <= '0;
      r_exc      <= 1'b0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_busy     <= 1'b1;
            r_sign     <= w_sign;
            r_exp      <= w_exp;
            r_mb       <= w_mb;
            r_rem      <= {1'b0, w_ma};
            r_q        <= '0;
            r_cnt      <= 5'(MW);
            r_spec     <= w_spec;
            r_spec_res <= w_spec_res;
            r_spec_flg <= w_spec_flg;
            r_state    <= w_spec ? S_NORM : S_DIV;
          end
        end
        S_DIV: begin
          r_rem <= w_next_rem;
          r_q   <= {r_q[MW-1:0], w_ge};
          if (r_cnt == '0) begin
            r_state <= S_NORM;
          end else begin
            r_cnt <= r_cnt - 5'd1;
          end
        end
        S_NORM: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
          if (r_spec) begin
            r_result <= r_spec_res;
            {r_exc, r_ovf, r_unf} <= r_spec_flg;
          end else if (w_e_n >= 10'sd255) begin
            r_result <= {r_sign, EMAX, MAN_W'(0)};
            {r_exc, r_ovf, r_unf} <= 3'b010;
          end else if (w_e_n <= 10'sd0) begin
            r_result <= {r_sign, 31'(0)};
            {r_exc, r_ovf, r_unf} <= 3'b001;
          end else begin
            r_result <= {r_sign, w_e_n[EXP_W-1:0], w_mant};
            {r_exc, r_ovf, r_unf} <= 3'b000;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.result    = r_result;
  assign bus.Exception = r_exc;
  assign bus.Overflow  = r_ovf;
  assign bus.Underflow = r_unf;

endmodule

// File: tb/tb_fp_division_seq.sv
// Bench for fp_division_seq: directed vectors, a value-level divide model
// and a per-cycle monitor of busy/done/result/flags.
module tb_fp_division_seq;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fp_division_seq_if bus();

  fp_division_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          acc;
    int          due;
    logic [31:0] res;
    logic [2:0]  flg;
  } exp_t;

  typedef struct {
    logic [31:0] res;
    logic [2:0]  flg;
    int          lat;
  } mres_t;

  exp_t        q[$];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          last_due = 0;
  logic [31:0] hold_res = '0;
  logic [2:0]  hold_flg = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h",
               nm, cyc, got, want);
    end
  endtask

  // Quotient from one wide integer divide, then IEEE packing rules
  function automatic mres_t model(input logic [31:0] a,
                                  input logic [31:0] b);
    mres_t       m;
    int          ea;
    int          eb;
    int          e;
    logic        s;
    longint      ma;
    longint      mb;
    longint      qq;
    logic [22:0] mant;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    m.lat = 1;
    m.flg = 3'b000;
    if (ea == 255 || eb == 255 || (ea == 0 && eb == 0)) begin
      m.res = 32'h7FC0_0000;
      m.flg = 3'b100;
    end else if (eb == 0) begin
      m.res = {s, 8'hFF, 23'h0};
      m.flg = 3'b110;
    end else if (ea == 0) begin
      m.res = {s, 31'h0};
    end else begin
      m.lat = 26;
      ma = longint'({1'b1, a[22:0]});
      mb = longint'({1'b1, b[22:0]});
      qq = (ma << 24) / mb;
      e  = ea - eb + 127;
      if (qq >= 64'h100_0000) begin
        mant = 23'(qq >> 1);
      end else begin
        mant = 23'(qq);
        e = e - 1;
      end
      if (e >= 255) begin
        m.res = {s, 8'hFF, 23'h0};
        m.flg = 3'b010;
      end else if (e <= 0) begin
        m.res = {s, 31'h0};
        m.flg = 3'b001;
      end else begin
        m.res = {s, 8'(e), mant};
      end
    end
    return m;
  endfunction

  always @(negedge clk) begin
    logic eb_;
    logic ed_;
    if (!reset) begin
      eb_ = 1'b0;
      ed_ = 1'b0;
      foreach (q[i])
        if (q[i].acc <= cyc && cyc < q[i].due) eb_ = 1'b1;
      if (q.size() > 0 && q[0].due == cyc) ed_ = 1'b1;
      chk("mon_busy", 32'(bus.busy), 32'(eb_));
      chk("mon_done", 32'(bus.done), 32'(ed_));
      if (ed_) begin
        hold_res = q[0].res;
        hold_flg = q[0].flg;
        void'(q.pop_front());
      end
      chk("mon_result", bus.result, hold_res);
      chk("mon_flags",
          32'({bus.Exception, bus.Overflow, bus.Underflow}),
          32'(hold_flg));
    end
  end

  task automatic issue(input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [31:0] lit,
                       input logic [2:0]  litf,
                       input int          hold);
    mres_t m;
    exp_t  e;
    m = model(a, b);
    chk("model_res", m.res, lit);
    chk("model_flg", 32'(m.flg), 32'(litf));
    bus.a_operand = a;
    bus.b_operand = b;
    bus.start     = 1'b1;
    e.acc = cyc + 1;
    e.due = cyc + 1 + m.lat;
    e.res = m.res;
    e.flg = m.flg;
    q.push_back(e);
    last_due = e.due;
    @(negedge clk);
    for (int i = 0; i < hold; i++) begin
      bus.a_operand = $urandom;
      bus.b_operand = $urandom;
      @(negedge clk);
    end
    bus.start     = 1'b0;
    bus.a_operand = $urandom;
    bus.b_operand = $urandom;
  endtask

  task automatic wait_idle(input string nm,
                           input logic [31:0] lit,
                           input logic [2:0]  litf);
    for (int i = 0; i < 60 && q.size() > 0; i++)
      @(negedge clk);
    if (q.size() > 0) begin
      chk({nm, "_timeout"}, 32'(q.size()), 32'd0);
      q.delete();
    end
    chk({nm, "_res"}, bus.result, lit);
    chk({nm, "_flg"},
        32'({bus.Exception, bus.Overflow, bus.Underflow}),
        32'(litf));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    bus.start     = 1'b0;
    bus.a_operand = '0;
    bus.b_operand = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_result", bus.result, 32'h0);
    chk("rst_flags",
        32'({bus.Exception, bus.Overflow, bus.Underflow}), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    issue(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 3'b000, 3);
    wait_idle("six_by_two", 32'h4040_0000, 3'b000);

    issue(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 3'b000, 0);
    wait_idle("one_third", 32'h3EAA_AAAA, 3'b000);

    issue(32'hC0F0_0000, 32'h4020_0000, 32'hC040_0000, 3'b000, 0);
    while (cyc < last_due) @(negedge clk);
    issue(32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 3'b010, 0);
    wait_idle("b2b_ovf", 32'h7F80_0000, 3'b010);

    issue(32'h0080_0000, 32'h4B80_0000, 32'h0000_0000, 3'b001, 0);
    wait_idle("underflow", 32'h0000_0000, 3'b001);

    issue(32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 3'b110, 0);
    wait_idle("div_zero", 32'h7F80_0000, 3'b110);

    issue(32'h7F80_0000, 32'h3F80_0000, 32'h7FC0_0000, 3'b100, 0);
    wait_idle("inf_op", 32'h7FC0_0000, 3'b100);

    issue(32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 3'b100, 0);
    wait_idle("zero_zero", 32'h7FC0_0000, 3'b100);

    issue(32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, 3'b000, 0);
    wait_idle("neg_zero", 32'h8000_0000, 3'b000);

    issue(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 3'b000, 0);
    repeat (8) @(negedge clk);
    reset = 1'b1;
    q.delete();
    hold_res = '0;
    hold_flg = '0;
    #1;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_result", bus.result, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    chk("midrst_nodone", 32'(bus.result), 32'h0);

    issue(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 3'b000, 0);
    wait_idle("after_rst", 32'h3EAA_AAAA, 3'b000);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
